cv32e40p_fpu_xif_result_tx: RTL and testbench

Result-channel transmitter on the coprocessor side of the CV-X-IF link between the cv32e40p core and the external FPNEW FPU (F-only, FLEN=32, 1-cycle pipe latency).
- Accepts completed FPU operations with a valid/ready handshake.
- Buffers them in an in-order FIFO.
- Drives the X-IF result channel toward the core, holding each payload stable under core backpressure.
- Supports a flush from the commit/kill path.

---
 rtl/cv32e40p_fpu_xif_result_tx.sv | 138 +++++++++++++
 tb/tb_cv32e40p_fpu_xif_result_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fpu_xif_result_tx.sv
// cv32e40p_fpu_xif_result_tx
// Coprocessor-side CV-X-IF result transmitter for the FPNEW FPU (F-only).
// Completed FPU operations are queued in an in-order FIFO. The head entry is
// presented on the X-IF result channel and stays stable until the core
// accepts it. A flush from the kill path discards everything buffered.

module cv32e40p_fpu_xif_result_tx #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned FLEN     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fpu_valid_i,
  output logic                       fpu_ready_o,
  input  logic [FLEN-1:0]            fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [ID_WIDTH-1:0]        fpu_id_i,
  input  logic [4:0]                 fpu_rd_i,
  input  logic                       fpu_we_i,
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [ID_WIDTH-1:0]        x_result_id_o,
  output logic [FLEN-1:0]            x_result_data_o,
  output logic [4:0]                 x_result_rd_o,
  output logic                       x_result_we_o,
  output logic [4:0]                 x_result_fflags_o,
  output logic                       x_result_fflags_we_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [FLEN-1:0]     data;
    logic [4:0]          status;
    logic [4:0]          rd;
    logic                we;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                stall_q, stall_d;
  logic [ID_WIDTH-1:0] stall_id_q, stall_id_d;

  logic   push;
  logic   pop;
  entry_t head;

  // Handshake qualifiers; ready/valid come from registered count only
  assign fpu_ready_o      = (count_q != CW'(DEPTH));
  assign x_result_valid_o = (count_q != '0);
  assign push             = fpu_valid_i && fpu_ready_o;
  assign pop              = x_result_valid_o && x_result_ready_i;
  assign head             = mem_q[rptr_q];

  // Payload is gated by valid so an empty channel always shows zeros
  assign x_result_id_o        = x_result_valid_o ? head.id     : '0;
  assign x_result_data_o      = x_result_valid_o ? head.data   : '0;
  assign x_result_rd_o        = x_result_valid_o ? head.rd     : '0;
  assign x_result_we_o        = x_result_valid_o ? head.we     : 1'b0;
  assign x_result_fflags_o    = x_result_valid_o ? head.status : '0;
  assign x_result_fflags_we_o = x_result_valid_o && (|head.status);
  assign occupancy_o          = count_q;
  assign overflow_o           = overflow_q;

  // Next-state for the FIFO: flush wins over push and pop in the same cycle
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q].id     = fpu_id_i;
        mem_d[wptr_q].data   = fpu_result_i;
        mem_d[wptr_q].status = fpu_status_i;
        mem_d[wptr_q].rd     = fpu_rd_i;
        mem_d[wptr_q].we     = fpu_we_i;
        wptr_d               = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Sticky error: the FPU changed its tag while being held off by !ready
  always_comb begin
    stall_d    = fpu_valid_i && !fpu_ready_o;
    stall_id_d = fpu_id_i;
    overflow_d = overflow_q;
    if (stall_d && stall_q && (fpu_id_i != stall_id_q)) begin
      overflow_d = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
      stall_id_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      stall_id_q <= stall_id_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fpu_xif_result_tx.sv
// tb_cv32e40p_fpu_xif_result_tx
// Directed bench for the FPU X-IF result transmitter. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.

module tb_cv32e40p_fpu_xif_result_tx;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_status;
  logic [3:0]  fpu_id;
  logic [4:0]  fpu_rd;
  logic        fpu_we;
  logic        x_valid;
  logic        x_ready;
  logic [3:0]  x_id;
  logic [31:0] x_data;
  logic [4:0]  x_rd;
  logic        x_we;
  logic [4:0]  x_fflags;
  logic        x_fflags_we;
  logic [1:0]  occupancy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cv32e40p_fpu_xif_result_tx #(
    .DEPTH(2), .ID_WIDTH(4), .FLEN(32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .fpu_valid_i          (fpu_valid),
    .fpu_ready_o          (fpu_ready),
    .fpu_result_i         (fpu_result),
    .fpu_status_i         (fpu_status),
    .fpu_id_i             (fpu_id),
    .fpu_rd_i             (fpu_rd),
    .fpu_we_i             (fpu_we),
    .x_result_valid_o     (x_valid),
    .x_result_ready_i     (x_ready),
    .x_result_id_o        (x_id),
    .x_result_data_o      (x_data),
    .x_result_rd_o        (x_rd),
    .x_result_we_o        (x_we),
    .x_result_fflags_o    (x_fflags),
    .x_result_fflags_we_o (x_fflags_we),
    .occupancy_o          (occupancy),
    .overflow_o           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_push(input logic [3:0] id, input logic [31:0] data,
                          input logic [4:0] status, input logic [4:0] rd,
                          input logic we);
    fpu_valid  = 1'b1;
    fpu_id     = id;
    fpu_result = data;
    fpu_status = status;
    fpu_rd     = rd;
    fpu_we     = we;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fpu_valid = 1'b0; x_ready = 1'b0;
    fpu_result = '0; fpu_status = '0; fpu_id = '0; fpu_rd = '0; fpu_we = 1'b0;
    step();
    step();
    checks++; if (x_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", x_valid); end
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", fpu_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d expected 0", occupancy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b expected 0", overflow); end
    checks++; if ({x_id, x_data, x_rd, x_we, x_fflags, x_fflags_we} !== 48'd0) begin
      errors++; $display("[TB] FAIL reset_payload got id=%h data=%h rd=%h we=%b ff=%h expected all 0", x_id, x_data, x_rd, x_we, x_fflags);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_op();
    x_ready = 1'b1;
    set_push(4'd3, 32'h3F80_0000, 5'b00001, 5'd7, 1'b0);
    checks++; if (x_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass got %b expected 0", x_valid); end
    step();
    fpu_valid = 1'b0;
    checks++; if (x_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b expected 1", x_valid); end
    checks++; if (x_id !== 4'd3) begin errors++; $display("[TB] FAIL single_id got %0d expected 3", x_id); end
    checks++; if (x_data !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL single_data got %h expected 3f800000", x_data); end
    checks++; if (x_rd !== 5'd7 || x_we !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_we got %0d/%b expected 7/0", x_rd, x_we); end
    checks++; if (x_fflags !== 5'b00001 || x_fflags_we !== 1'b1) begin errors++; $display("[TB] FAIL single_fflags got %b/%b expected 00001/1", x_fflags, x_fflags_we); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL single_occ got %0d expected 1", occupancy); end
    step();
    checks++; if (x_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL single_pop got valid=%b occ=%0d expected 0/0", x_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    x_ready = 1'b0;
    set_push(4'd1, 32'hA000_0001, 5'd0, 5'd9, 1'b0);
    step();
    set_push(4'd2, 32'hA000_0002, 5'b10000, 5'd10, 1'b1);
    step();
    checks++; if (occupancy !== 2'd2 || fpu_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got occ=%0d ready=%b expected 2/0", occupancy, fpu_ready); end
    set_push(4'd3, 32'hA000_0003, 5'b00100, 5'd11, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (x_id !== 4'd1 || x_data !== 32'hA000_0001 || x_rd !== 5'd9 || x_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_stable got id=%0d data=%h rd=%0d valid=%b expected 1/a0000001/9/1", x_id, x_data, x_rd, x_valid);
      end
      checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL bp_held got occ=%0d expected 2", occupancy); end
    end
    x_ready = 1'b1;
    step();
    checks++; if (x_id !== 4'd2 || x_data !== 32'hA000_0002 || x_we !== 1'b1 || x_fflags_we !== 1'b1 || occupancy !== 2'd1) begin
      errors++; $display("[TB] FAIL bp_second got id=%0d data=%h we=%b ffwe=%b occ=%0d expected 2/a0000002/1/1/1", x_id, x_data, x_we, x_fflags_we, occupancy);
    end
    step();
    fpu_valid = 1'b0;
    checks++; if (x_id !== 4'd3 || x_data !== 32'hA000_0003 || x_fflags !== 5'b00100 || occupancy !== 2'd1) begin
      errors++; $display("[TB] FAIL bp_third got id=%0d data=%h ff=%b occ=%0d expected 3/a0000003/00100/1", x_id, x_data, x_fflags, occupancy);
    end
    step();
    checks++; if (x_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL bp_drain got valid=%b occ=%0d expected 0/0", x_valid, occupancy); end
  endtask

  task automatic test_back_to_back();
    x_ready = 1'b1;
    set_push(4'd4, 32'hB000_0004, 5'd0, 5'd4, 1'b0);
    step();
    checks++; if (x_id !== 4'd4 || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL b2b_first got id=%0d occ=%0d expected 4/1", x_id, occupancy); end
    set_push(4'd5, 32'hB000_0005, 5'd0, 5'd5, 1'b0);
    step();
    checks++; if (x_id !== 4'd5 || x_data !== 32'hB000_0005 || occupancy !== 2'd1) begin
      errors++; $display("[TB] FAIL b2b_pushpop got id=%0d data=%h occ=%0d expected 5/b0000005/1", x_id, x_data, occupancy);
    end
    set_push(4'd6, 32'hB000_0006, 5'd0, 5'd6, 1'b0);
    step();
    fpu_valid = 1'b0;
    checks++; if (x_id !== 4'd6 || x_rd !== 5'd6 || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL b2b_wrap got id=%0d rd=%0d occ=%0d expected 6/6/1", x_id, x_rd, occupancy); end
    step();
    checks++; if (x_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %b expected 0", x_valid); end
  endtask

  task automatic test_feq();
    x_ready = 1'b0;
    set_push(4'd8, 32'h0000_0001, 5'd0, 5'd12, 1'b1);
    step();
    fpu_valid = 1'b0;
    checks++; if (x_we !== 1'b1 || x_fflags_we !== 1'b0 || x_data !== 32'h0000_0001 || x_fflags !== 5'd0) begin
      errors++; $display("[TB] FAIL feq got we=%b ffwe=%b data=%h ff=%b expected 1/0/00000001/00000", x_we, x_fflags_we, x_data, x_fflags);
    end
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
  endtask

  task automatic test_flush();
    x_ready = 1'b0;
    set_push(4'd1, 32'hC000_0001, 5'd0, 5'd1, 1'b0);
    step();
    set_push(4'd2, 32'hC000_0002, 5'd0, 5'd2, 1'b0);
    step();
    set_push(4'd12, 32'hC000_000C, 5'd0, 5'd3, 1'b0);
    flush = 1'b1;
    step();
    checks++; if (x_valid !== 1'b0 || occupancy !== 2'd0 || fpu_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_full got valid=%b occ=%0d ready=%b expected 0/0/1", x_valid, occupancy, fpu_ready);
    end
    flush = 1'b0;
    set_push(4'd10, 32'hC000_000A, 5'd0, 5'd4, 1'b0);
    step();
    set_push(4'd11, 32'hC000_000B, 5'd0, 5'd5, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (occupancy !== 2'd0 || x_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_push got occ=%0d valid=%b expected 0/0", occupancy, x_valid); end
    set_push(4'd13, 32'hC000_000D, 5'd0, 5'd6, 1'b0);
    step();
    fpu_valid = 1'b0;
    checks++; if (x_id !== 4'd13 || x_data !== 32'hC000_000D || occupancy !== 2'd1) begin
      errors++; $display("[TB] FAIL flush_after got id=%0d data=%h occ=%0d expected 13/c000000d/1", x_id, x_data, occupancy);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_overflow got %b expected 0", overflow); end
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
  endtask

  task automatic test_overflow();
    x_ready = 1'b0;
    set_push(4'd1, 32'hD000_0001, 5'd0, 5'd1, 1'b0);
    step();
    set_push(4'd2, 32'hD000_0002, 5'd0, 5'd2, 1'b0);
    step();
    set_push(4'd5, 32'hD000_0005, 5'd0, 5'd3, 1'b0);
    step();
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_held_ok got %b expected 0", overflow); end
    fpu_id = 4'd6;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b expected 1", overflow); end
    fpu_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++; if (overflow !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL ovf_sticky got ovf=%b occ=%0d expected 1/0", overflow, occupancy); end
  endtask

  task automatic test_async_reset();
    x_ready = 1'b0;
    set_push(4'd9, 32'hE000_0009, 5'b00011, 5'd9, 1'b1);
    step();
    fpu_valid = 1'b0;
    checks++; if (x_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre got %b expected 1", x_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (x_valid !== 1'b0 || fpu_ready !== 1'b1 || occupancy !== 2'd0 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL areset_ctrl got valid=%b ready=%b occ=%0d ovf=%b expected 0/1/0/0", x_valid, fpu_ready, occupancy, overflow);
    end
    checks++; if ({x_id, x_data, x_rd, x_we, x_fflags, x_fflags_we} !== 48'd0) begin
      errors++; $display("[TB] FAIL areset_payload got id=%h data=%h rd=%h we=%b ff=%h expected all 0", x_id, x_data, x_rd, x_we, x_fflags);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_feq();
    test_flush();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
